// File: rtl/hv_to_axi4_video_conv_if.sv
// AXI4-Stream video bus: tuser marks start-of-frame, tlast marks end-of-line.
// Structural only; tready is the sole backpressure path.
interface axi4_stream_if #(
  parameter int DATA_W = 30
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/hv_to_axi4_video_conv.sv
// Rebuilds AXI4-Stream video (tuser=SOF, tlast=EOL) from decoded HV video; bad frames dropped until next v_sync.
// px_valid -> tvalid is 2 cycles; tready stalls drain a FIFO, and a write into a full FIFO drops the frame.

module hv_to_axi4_video_conv_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         wr_vld_i,
  input  logic [W-1:0] wr_dat_i,
  output logic         full_o,
  output logic         rd_vld_o,
  input  logic         rd_rdy_i,
  output logic [W-1:0] rd_dat_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          wr_en;
  logic          rd_en;

  // full is derived from registered pointers, so a same-cycle pop never frees room for a push
  assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_vld_o = (wr_ptr_q != rd_ptr_q);
  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_en    = wr_vld_i && !full_o;
  assign rd_en    = rd_vld_o && rd_rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
  end
endmodule

module hv_to_axi4_video_conv #(
  parameter int X_RES      = 1920,
  parameter int Y_RES      = 1080,
  parameter int PX_WIDTH   = 10,
  parameter int FIFO_DEPTH = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] red_i,
  input  logic [7:0] green_i,
  input  logic [7:0] blue_i,
  input  logic       px_valid_i,
  input  logic       h_sync_i,
  input  logic       v_sync_i,
  axi4_stream_if.master video_o,
  output logic       overflow_o,
  output logic       frame_err_o
);
  localparam int DW  = 3 * PX_WIDTH;
  localparam int PAD = PX_WIDTH - 8;
  localparam int XW  = $clog2(X_RES + 1);
  localparam int YW  = $clog2(Y_RES + 1);

  typedef enum logic [1:0] {WAIT_VSYNC, WAIT_SOF, ACTIVE, DROP} state_t;

  typedef struct packed {
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tuser;
  } px_t;

  logic [7:0] red_q, green_q, blue_q;
  logic       pv_q, hs_q, vs_q, vs_prev_q;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           line_done_q, line_done_d;
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;

  logic           vs_rise;
  logic           pix;
  logic           wr_req;
  logic           fifo_full;
  logic           fifo_vld;
  px_t            wr_px;
  px_t            rd_px;
  logic [DW-1:0]  pix_dat;

  assign vs_rise = vs_q && !vs_prev_q;
  // a strobe coinciding with h_sync cannot be active video, so it is not counted as a pixel
  assign pix     = pv_q && !hs_q;
  assign pix_dat = {PX_WIDTH'(red_q) << PAD, PX_WIDTH'(green_q) << PAD, PX_WIDTH'(blue_q) << PAD};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      pv_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      state_q     <= WAIT_VSYNC;
      x_q         <= '0;
      y_q         <= '0;
      line_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      red_q       <= red_i;
      green_q     <= green_i;
      blue_q      <= blue_i;
      pv_q        <= px_valid_i;
      hs_q        <= h_sync_i;
      vs_q        <= v_sync_i;
      vs_prev_q   <= vs_q;
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      line_done_q <= line_done_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    line_done_d = line_done_q && pix;
    ovf_d       = ovf_q;
    err_d       = 1'b0;
    case (state_q)
      WAIT_VSYNC, DROP: begin
        if (vs_rise) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (pix) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (vs_rise) begin
          err_d       = 1'b1;
          state_d     = WAIT_SOF;
          x_d         = '0;
          y_d         = '0;
          line_done_d = 1'b0;
        end else if ((!pix && x_q != '0) || (pix && line_done_q)) begin
          err_d       = 1'b1;
          state_d     = DROP;
          x_d         = '0;
          y_d         = '0;
          line_done_d = 1'b0;
        end
      end
    endcase
    if (wr_req) begin
      if (fifo_full) begin
        ovf_d       = 1'b1;
        state_d     = DROP;
        x_d         = '0;
        y_d         = '0;
        line_done_d = 1'b0;
      end else if (wr_px.tlast) begin
        x_d         = '0;
        line_done_d = 1'b1;
        if (y_q == YW'(Y_RES - 1)) begin
          state_d     = WAIT_VSYNC;
          y_d         = '0;
          line_done_d = 1'b0;
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    wr_req = 1'b0;
    case (state_q)
      WAIT_SOF: wr_req = pix;
      ACTIVE:   wr_req = pix && !vs_rise && !line_done_q;
      default:  wr_req = 1'b0;
    endcase
    wr_px.tdata = pix_dat;
    wr_px.tlast = (x_q == XW'(X_RES - 1));
    wr_px.tuser = (state_q == WAIT_SOF);
  end

  hv_to_axi4_video_conv_fifo #(
    .W     ($bits(px_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_vld_i (wr_req),
    .wr_dat_i (wr_px),
    .full_o   (fifo_full),
    .rd_vld_o (fifo_vld),
    .rd_rdy_i (video_o.tready),
    .rd_dat_o (rd_px)
  );

  assign video_o.tvalid = fifo_vld;
  assign video_o.tdata  = rd_px.tdata;
  assign video_o.tlast  = rd_px.tlast;
  assign video_o.tuser  = rd_px.tuser;
  assign overflow_o     = ovf_q;
  assign frame_err_o    = err_q;
endmodule
